ir_tx_scheduler: RTL and testbench
==================================

Name: ir_tx_scheduler

Overview:
Shares the single NEC IR transmitter among NUM_REQ requesters using a round-robin arbiter. It latches the winner's 8-bit address and command, then issues a one-cycle send pulse to the transmitter. It tracks the transmitter's busy flag through the frame and enforces a minimum inter-frame gap. It replaces the free-running test-pattern sender in the top level and sits between user logic (keys, decoder loopback, host) and the IR transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2000000, idle clocks enforced after each frame (40 ms at 50 MHz)
ACK_TIMEOUT, 1024, clocks allowed for the transmitter to raise busy after a send pulse

Ports:
iCLK_50  in  1  50 MHz clock
iRST_n  in  1  asynchronous active-low reset
iREQ  in  NUM_REQ  per-requester request level
iADDR  in  8*NUM_REQ  per-requester address; requester i uses bits [8i+7:8i]
iCMD  in  8*NUM_REQ  per-requester command; same packing as iADDR
oGNT  out  NUM_REQ  one-hot grant, held for the whole frame
oDONE  out  NUM_REQ  one-cycle completion pulse to the granted requester
oERR  out  1  one-cycle pulse coincident with oDONE when the frame timed out
oBUSY  out  1  high whenever state is not IDLE
oTX_ADDRESS  out  8  latched address to the transmitter
oTX_COMMAND  out  8  latched command to the transmitter
oTX_SEND  out  1  one-cycle send strobe to the transmitter
iTX_BUSY  in  1  transmitter busy flag

Behaviour:
- Reset (async, iRST_n=0) values:
  - state=IDLE, oGNT=0, oDONE=0, oERR=0, oBUSY=0, oTX_SEND=0.
  - oTX_ADDRESS=0, oTX_COMMAND=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - Reset mid-frame abandons the frame silently; no oDONE is issued.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - When any iREQ bit is high and iTX_BUSY=0, pick the winner: first set bit searching upward from the RR pointer, wrapping modulo NUM_REQ.
  - On that edge: latch the winner's iADDR/iCMD into oTX_ADDRESS/oTX_COMMAND, set oGNT one-hot, go to SEND.
  - If iTX_BUSY=1 in IDLE, no grant is made (wait).
- SEND:
  - oTX_SEND=1 for exactly one cycle; next state WAIT_BUSY.
  - Latency: request seen in IDLE at edge N -> oTX_SEND high during cycle N+1.
- WAIT_BUSY:
  - iTX_BUSY=1 -> WAIT_DONE.
  - A counter runs from the SEND exit. If it reaches ACK_TIMEOUT without iTX_BUSY: pulse oDONE[winner] and oERR, clear oGNT, go to IDLE with no gap.
- WAIT_DONE:
  - On iTX_BUSY falling to 0: pulse oDONE[winner] for 1 cycle, clear oGNT, set RR pointer=(winner+1) mod NUM_REQ, go to GAP.
  - No timeout in this state.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
  - GAP_CYCLES=0 means go to IDLE on the next cycle.
  - Requests are ignored during GAP.
- Requester rules:
  - iREQ is a level. A requester deasserting before grant simply withdraws.
  - Deasserting iREQ or changing iADDR/iCMD after grant has no effect on the frame in flight.
  - A requester still high after its oDONE competes again; the RR pointer gives others precedence.
- Simultaneous events:
  - All requesters high -> grants rotate 0,1,2,3,0...
  - The pointer advances only on a completed frame, not on a timeout.
- Counters: width ceil(log2(max(GAP_CYCLES, ACK_TIMEOUT)+1)); no wrap beyond terminal count.

Optional Feature:
IR_TX_SCHED_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, lowest index wins; the RR pointer logic is removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
1. GAP_CYCLES=16. Reset, then iREQ=0001 with iADDR[7:0]=8'h5A, iCMD[7:0]=8'hC3. Model busy high 3 cycles after send for 200 cycles -> oTX_SEND one pulse with 5A/C3, oGNT=0001 throughout, oDONE[0] pulse 1 cycle after busy falls, next grant no earlier than 16 cycles later.
2. iREQ=1111 held -> grant order 0,1,2,3,0. Each oTX_SEND separated by frame time + 16 + 2 cycles. Under IR_TX_SCHED_FIXED_PRIO_EN, the order is 0,0,0,...
3. Transmitter model never raises busy, ACK_TIMEOUT=1024 -> oDONE[winner] and oERR pulse together exactly 1024 cycles after SEND, return to IDLE, RR pointer unchanged.
4. Drive iREQ=0100 and change iADDR[23:16] from 8'h11 to 8'h22 one cycle after oGNT rises -> transmitter sees 8'h11 only.
5. Assert iRST_n=0 during WAIT_DONE -> all outputs zero immediately, no oDONE. After release, IDLE with RR pointer=0.
6. iTX_BUSY=1 held externally in IDLE with iREQ=0010 -> no oGNT or oTX_SEND until busy drops, then grant on the next edge.

Source files
------------

// File: rtl/ir_tx_scheduler_if.sv
// Transmitter-side bus of the IR TX scheduler: latched frame fields, the send strobe
// and the transmitter busy flag.
interface ir_tx_scheduler_if;
  logic [7:0] oTX_ADDRESS;
  logic [7:0] oTX_COMMAND;
  logic       oTX_SEND;
  logic       iTX_BUSY;

  modport master (
    output oTX_ADDRESS,
    output oTX_COMMAND,
    output oTX_SEND,
    input  iTX_BUSY
  );

  modport slave (
    input  oTX_ADDRESS,
    input  oTX_COMMAND,
    input  oTX_SEND,
    output iTX_BUSY
  );
endinterface

// File: rtl/ir_tx_scheduler.sv
// Round-robin scheduler sharing one NEC IR transmitter among NUM_REQ requesters.
// Define IR_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
//
// state       | meaning
// S_IDLE      | waiting for a request while the transmitter is idle
// S_SEND      | one-cycle send strobe to the transmitter
// S_WAIT_BUSY | waiting for the transmitter to raise busy (bounded by ACK_TIMEOUT)
// S_WAIT_DONE | frame in flight, waiting for busy to fall
// S_GAP       | enforced inter-frame silence of GAP_CYCLES clocks
module ir_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2000000,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                   iCLK_50,
  input  logic                   iRST_n,
  input  logic [NUM_REQ-1:0]     iREQ,
  input  logic [8*NUM_REQ-1:0]   iADDR,
  input  logic [8*NUM_REQ-1:0]   iCMD,
  output logic [NUM_REQ-1:0]     oGNT,
  output logic [NUM_REQ-1:0]     oDONE,
  output logic                   oERR,
  output logic                   oBUSY,
  ir_tx_scheduler_if.master      tx
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Loaded on the grant edge so the timeout counts from the send strobe itself.
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           cmd_q, cmd_d;

  logic [IDX_W-1:0]     base;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     arb_idx;
  logic                 req_any;

`ifdef IR_TX_SCHED_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  assign base = ptr_q;
`endif

  // Scan from the highest offset down so the last hit is the first requester at/after base.
  always_comb begin
    arb_idx = '0;
    req_any = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(base) + k) % NUM_REQ);
      if (iREQ[cand]) begin
        arb_idx = cand;
        req_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
`ifndef IR_TX_SCHED_FIXED_PRIO_EN
    ptr_d   = ptr_q;
    win_d   = win_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_any && !tx.iTX_BUSY) begin
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
          addr_d  = iADDR[{arb_idx, 3'b000} +: 8];
          cmd_d   = iCMD[{arb_idx, 3'b000} +: 8];
          cnt_d   = ACK_LOAD;
          state_d = S_SEND;
`ifndef IR_TX_SCHED_FIXED_PRIO_EN
          win_d   = arb_idx;
`endif
        end
      end
      S_SEND: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx.iTX_BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == '0) begin
          // Timed-out frames leave the pointer alone and skip the gap.
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx.iTX_BUSY) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
`ifndef IR_TX_SCHED_FIXED_PRIO_EN
          ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
`endif
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
`ifndef IR_TX_SCHED_FIXED_PRIO_EN
      ptr_q   <= '0;
      win_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
`ifndef IR_TX_SCHED_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
      win_q   <= win_d;
`endif
    end
  end

  assign oGNT           = gnt_q;
  assign oDONE          = done_q;
  assign oERR           = err_q;
  assign oBUSY          = (state_q != S_IDLE);
  assign tx.oTX_ADDRESS = addr_q;
  assign tx.oTX_COMMAND = cmd_q;
  assign tx.oTX_SEND    = (state_q == S_SEND);

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler with a simple NEC transmitter busy model.
module tb_ir_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int GAP     = 16;
  localparam int ACK     = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] addr = '0;
  logic [31:0] cmd = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        busy;

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  bit   model_en = 1'b0;
  int   model_len = 200;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ir_tx_scheduler_if tx();
  assign tx.iTX_BUSY = model_busy | force_busy;

  ir_tx_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .iCLK_50(clk), .iRST_n(rst_n), .iREQ(req), .iADDR(addr), .iCMD(cmd),
    .oGNT(gnt), .oDONE(done), .oERR(err), .oBUSY(busy), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: busy rises 3 cycles after the send strobe and stays high model_len cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (model_en && tx.oTX_SEND === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (model_len) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_send(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (tx.oTX_SEND === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done !== 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (tx.oTX_SEND !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", tx.oTX_SEND); end
    n_checks++; if (tx.oTX_ADDRESS !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", tx.oTX_ADDRESS); end
    n_checks++; if (tx.oTX_COMMAND !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %h expected 00", tx.oTX_COMMAND); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    bit ok, ok2;
    int ts, td, gnt_bad, extra;
    do_reset();
    model_en = 1'b1; model_len = 200;
    addr[7:0] = 8'h5A; cmd[7:0] = 8'hC3; req = 4'b0001;
    wait_send(10, ok);
    ts = cyc;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_send: got no strobe expected one within 10 cycles"); end
    n_checks++; if (tx.oTX_ADDRESS !== 8'h5A) begin n_fail++; $display("FAIL single_addr: got %h expected 5a", tx.oTX_ADDRESS); end
    n_checks++; if (tx.oTX_COMMAND !== 8'hC3) begin n_fail++; $display("FAIL single_cmd: got %h expected c3", tx.oTX_COMMAND); end
    gnt_bad = 0; extra = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done !== 4'b0000) begin ok = 1'b1; break; end
      if (gnt !== 4'b0001) gnt_bad++;
      if (tx.oTX_SEND === 1'b1) extra++;
    end
    td = cyc;
    n_checks++; if (gnt_bad != 0) begin n_fail++; $display("FAIL single_gnt_held: got %0d bad cycles expected 0", gnt_bad); end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL single_one_strobe: got %0d extra strobes expected 0", extra); end
    n_checks++; if (!ok || td != ts + 204) begin n_fail++; $display("FAIL single_done_time: got %0d expected %0d", td - ts, 204); end
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b expected 0001", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", err); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_clear: got %b expected 0000", gnt); end
    tick();
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_width: got %b expected 0000", done); end
    wait_send(60, ok);
    n_checks++; if (!ok || cyc != td + 17) begin n_fail++; $display("FAIL single_gap: got %0d expected %0d", cyc - td, 17); end
    req = '0;
    wait_done(400, ok); wait_idle(40, ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL single_drain: got done=%b idle=%b expected 1 1", ok, ok2); end
  endtask

  task automatic test_round_robin();
    bit ok, ok2;
    int prev, exp_w;
    do_reset();
    model_en = 1'b1; model_len = 20;
    for (int i = 0; i < 4; i++) begin
      addr[8*i +: 8] = 8'h10 + 8'(i);
      cmd[8*i +: 8]  = 8'hA0 + 8'(i);
    end
    req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
`ifdef IR_TX_SCHED_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = i % 4;
`endif
      wait_send(100, ok);
      n_checks++; if (!ok || gnt !== 4'(1 << exp_w)) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", i, gnt, 4'(1 << exp_w)); end
      n_checks++; if (tx.oTX_ADDRESS !== 8'h10 + 8'(exp_w)) begin n_fail++; $display("FAIL rr_addr%0d: got %h expected %h", i, tx.oTX_ADDRESS, 8'h10 + 8'(exp_w)); end
      if (i > 0) begin
        n_checks++; if (cyc - prev != 41) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d expected 41", i, cyc - prev); end
      end
      prev = cyc;
    end
    req = '0;
    wait_done(200, ok); wait_idle(40, ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL rr_drain: got done=%b idle=%b expected 1 1", ok, ok2); end
  endtask

  task automatic test_timeout();
    bit ok, ok2;
    int ts, td;
    do_reset();
    model_en = 1'b0;
    req = 4'b0001;
    wait_send(10, ok);
    ts = cyc;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_send: got no strobe expected one"); end
    req = 4'b0011;
    wait_done(1100, ok);
    td = cyc;
    n_checks++; if (!ok || td != ts + ACK) begin n_fail++; $display("FAIL to_time: got %0d expected %0d", td - ts, ACK); end
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL to_done: got %b expected 0001", done); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", err); end
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got gnt=%b busy=%b expected 0000 0", gnt, busy); end
    model_en = 1'b1; model_len = 20;
    tick();
    n_checks++; if (err !== 1'b0 || done !== 4'b0000) begin n_fail++; $display("FAIL to_pulse_width: got err=%b done=%b expected 0 0000", err, done); end
    n_checks++; if (tx.oTX_SEND !== 1'b1 || gnt !== 4'b0001) begin n_fail++; $display("FAIL to_ptr_kept: got send=%b gnt=%b expected 1 0001", tx.oTX_SEND, gnt); end
    req = '0;
    wait_done(200, ok); wait_idle(40, ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL to_drain: got done=%b idle=%b expected 1 1", ok, ok2); end
  endtask

  task automatic test_latch();
    bit ok, ok2;
    do_reset();
    model_en = 1'b1; model_len = 20;
    addr = '0; cmd = '0;
    addr[23:16] = 8'h11; cmd[23:16] = 8'h33;
    req = 4'b0100;
    wait_send(10, ok);
    n_checks++; if (!ok || gnt !== 4'b0100) begin n_fail++; $display("FAIL latch_gnt: got %b expected 0100", gnt); end
    n_checks++; if (tx.oTX_ADDRESS !== 8'h11) begin n_fail++; $display("FAIL latch_addr_send: got %h expected 11", tx.oTX_ADDRESS); end
    tick();
    addr[23:16] = 8'h22; cmd[23:16] = 8'h44; req = '0;
    wait_done(200, ok);
    n_checks++; if (!ok || done !== 4'b0100) begin n_fail++; $display("FAIL latch_done: got %b expected 0100", done); end
    n_checks++; if (tx.oTX_ADDRESS !== 8'h11 || tx.oTX_COMMAND !== 8'h33) begin n_fail++; $display("FAIL latch_hold: got %h/%h expected 11/33", tx.oTX_ADDRESS, tx.oTX_COMMAND); end
    wait_idle(40, ok2);
    n_checks++; if (!ok2) begin n_fail++; $display("FAIL latch_drain: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, ok2;
    int n_done, n_gnt;
    do_reset();
    model_en = 1'b1; model_len = 50;
    req = 4'b0001;
    wait_send(10, ok);
    req = '0;
    wait_done(200, ok); wait_idle(40, ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL rst_first_frame: got done=%b idle=%b expected 1 1", ok, ok2); end
    req = 4'b1000;
    wait_send(10, ok);
    n_checks++; if (!ok || gnt !== 4'b1000) begin n_fail++; $display("FAIL rst_second_gnt: got %b expected 1000", gnt); end
    repeat (10) tick();
    n_checks++; if (busy !== 1'b1 || gnt !== 4'b1000) begin n_fail++; $display("FAIL rst_in_frame: got busy=%b gnt=%b expected 1 1000", busy, gnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || err !== 1'b0 || busy !== 1'b0 || tx.oTX_SEND !== 1'b0)
      begin n_fail++; $display("FAIL rst_async_ctl: got gnt=%b done=%b err=%b busy=%b send=%b expected all zero", gnt, done, err, busy, tx.oTX_SEND); end
    n_checks++; if (tx.oTX_ADDRESS !== 8'h00 || tx.oTX_COMMAND !== 8'h00) begin n_fail++; $display("FAIL rst_async_data: got %h/%h expected 00/00", tx.oTX_ADDRESS, tx.oTX_COMMAND); end
    req = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    n_done = 0; n_gnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done !== 4'b0000) n_done++;
      if (gnt !== 4'b0000) n_gnt++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses expected 0", n_done); end
    n_checks++; if (n_gnt != 0) begin n_fail++; $display("FAIL rst_no_gnt: got %0d cycles expected 0", n_gnt); end
    req = 4'b1001;
    wait_send(10, ok);
    n_checks++; if (!ok || gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_zero: got %b expected 0001", gnt); end
    req = '0;
    wait_done(200, ok); wait_idle(40, ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL rst_drain: got done=%b idle=%b expected 1 1", ok, ok2); end
  endtask

  task automatic test_busy_hold();
    bit ok, ok2;
    int hits;
    do_reset();
    model_en = 1'b0;
    force_busy = 1'b1;
    req = 4'b0010;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt !== 4'b0000 || tx.oTX_SEND !== 1'b0) hits++;
    end
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL busy_hold_blocked: got %0d grant cycles expected 0", hits); end
    model_en = 1'b1; model_len = 20;
    force_busy = 1'b0;
    tick();
    n_checks++; if (gnt !== 4'b0010 || tx.oTX_SEND !== 1'b1) begin n_fail++; $display("FAIL busy_hold_release: got gnt=%b send=%b expected 0010 1", gnt, tx.oTX_SEND); end
    req = '0;
    wait_done(200, ok); wait_idle(40, ok2);
    n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL busy_hold_drain: got done=%b idle=%b expected 1 1", ok, ok2); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_latch();
    test_reset_mid_frame();
    test_busy_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
